fwd_hazard_ctrl: RTL
====================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Controls the pipeline's two 3-input forwarding muxes (ALU operand A/B) and sequences load-use stalls.
//  - Tracks destination-register tags for the EX, MEM and WB stages in internal shift registers.
//  - Drives registered mux selects into EX: 2'b00 = regfile, 2'b01 = WB result, 2'b10 = MEM result.
//  - Drives Stall (hold PC and IF/ID) and inserts a bubble into ID/EX.
//  - Sits beside the ID/EX pipeline register; fed by decode and the branch unit.
// PARAMETERS
//  REG_AW        5   register-address width
//  R0_HARDWIRED  1   1: register 0 is never forwarded and never causes a stall
//  CNT_W        16   width of the stall counter (optional feature only)
// PORTS
//  Clk         in   1       rising-edge clock
//  Reset_n     in   1       synchronous, active-low reset
//  ID_Rs       in   REG_AW  source register A of the instruction in ID
//  ID_Rt       in   REG_AW  source register B of the instruction in ID
//  ID_UsesRt   in   1       ID instruction reads Rt (0 for immediate ops)
//  ID_Rd       in   REG_AW  destination register of the ID instruction
//  ID_RegWrite in   1       ID instruction writes Rd
//  ID_MemRead  in   1       ID instruction is a load
//  Br_Taken    in   1       branch resolved taken in EX; flush ID and EX
//  ForwardA    out  2       operand-A mux select, valid during EX
//  ForwardB    out  2       operand-B mux select, valid during EX
//  Stall       out  1       combinational; hold PC and IF/ID this cycle
//  Bubble      out  1       combinational; ID/EX loads a NOP this cycle
//  Stall_Cnt   out  CNT_W   stall cycles since reset (HAZ_STALL_CNT_EN only)
// BEHAVIOUR
//  Reset (Reset_n=0 at the edge):
//  - All stage tags are cleared (RegWrite=0, MemRead=0, Rd=0).
//  - ForwardA = ForwardB = 2'b00; Stall_Cnt = 0.
//  - Stall and Bubble evaluate to 0 next cycle, because the tags are empty.
//  - A reset mid-stall abandons the stall; no state survives.
//  Stage tags per edge:
//  - WB <= MEM.
//  - MEM <= EX.
//  - EX <= ID fields, or a NOP tag (all zero) if Bubble=1.
//  Stall (combinational):
//  - Stall = EX.MemRead & EX.RegWrite & EX.Rd != 0
//    & (EX.Rd == ID_Rs | (ID_UsesRt & EX.Rd == ID_Rt)).
//  - Bubble = Stall | Br_Taken.
//  - Br_Taken has priority: when Br_Taken=1, Stall is forced to 0.
//  - The ID instruction is discarded upstream, so no stall is needed.
//  - A load-use stall lasts exactly 1 cycle. Next cycle the load is in MEM (not EX), so the condition clears.
//  Forward selects, registered at each edge, per source S in {Rs, Rt}:
//  - 2'b10 if EX.RegWrite & EX.Rd == S & !EX.MemRead, because EX moves to MEM.
//  - else 2'b01 if MEM.RegWrite & MEM.Rd == S, because MEM moves to WB.
//  - else 2'b00.
//  - MEM/younger match wins over WB match (most recent producer).
//  - S == 0 with R0_HARDWIRED=1 -> 2'b00.
//  - ID_UsesRt=0 -> ForwardB = 2'b00.
//  - A load in EX never yields 2'b10. The stall covers it, and the consumer then gets 2'b01.
//  - On a Bubble edge, ForwardA/ForwardB <= 2'b00.
//  - 2'b11 is never driven.
//  Latency: selects are valid 1 cycle after the instruction is presented in ID, aligned with its EX cycle.
// CONFIGURATION
//  HAZ_STALL_CNT_EN defined:
//  - Stall_Cnt increments on every edge where Stall=1 and Reset_n=1.
//  - It saturates at all-ones; no wrap.
//  HAZ_STALL_CNT_EN undefined:
//  - Stall_Cnt is tied to 0 and no counter logic is present.
//  - The port remains for a stable interface.
// TESTING
//  1. Reset: Reset_n=0 for 2 cycles with random inputs -> ForwardA/B=00, Stall=0, Stall_Cnt=0.
//  2. EX->EX forward: add r3 in ID, then sub using Rs=r3 next cycle -> ForwardA=10 in sub's EX, Stall=0.
//  3. WB forward and priority:
//     - Sequence: write r5, independent op, then reader of r5 -> ForwardA=01.
//     - Sequence: write r5 twice, then reader -> ForwardA=10 (younger wins).
//  4. Load-use:
//     - lw r7, then add Rs=r7 -> Stall=1 and Bubble=1 for exactly 1 cycle, then ForwardA=01 in add's EX.
//     - Stall_Cnt=1 with HAZ_STALL_CNT_EN defined, 0 without.
//  5. r0 and immediates:
//     - Write r0, then read r0 -> ForwardA=00.
//     - lw r0, then read r0 -> no stall.
//     - Rt match with ID_UsesRt=0 -> ForwardB=00, no stall.
//  6. Flush vs stall:
//     - Load-use condition with Br_Taken=1 in the same cycle -> Stall=0, Bubble=1, next ForwardA/B=00.
//     - Reset_n=0 during a stall cycle -> Stall=0 next cycle.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for the EX stage ALU operand muxes.
// Define HAZ_STALL_CNT_EN to build the saturating stall-cycle counter behind Stall_Cnt.
module fwd_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int R0_HARDWIRED = 1,
    parameter int CNT_W        = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_UsesRt,
    input  logic [REG_AW-1:0] ID_Rd,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              Br_Taken,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              Stall,
    output logic              Bubble,
    output logic [CNT_W-1:0]  Stall_Cnt
);

    // A producer sitting in WB retires into the regfile at the edge, so its tag
    // is never a forwarding source and only the EX and MEM tags are kept.
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_regwrite;
    logic              r_ex_memread;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_regwrite;
    logic [1:0]        r_fwd_a;
    logic [1:0]        r_fwd_b;

    logic              w_ex_load_live;
    logic              w_stall;
    logic              w_bubble;
    logic [1:0]        w_sel_a;
    logic [1:0]        w_sel_b;

    function automatic logic is_r0(input logic [REG_AW-1:0] r);
        return (R0_HARDWIRED != 0) && (r == '0);
    endfunction

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] ex_rd,
        input logic              ex_rw,
        input logic              ex_mr,
        input logic [REG_AW-1:0] mem_rd,
        input logic              mem_rw
    );
        if (is_r0(src)) return 2'b00;
        if (ex_rw && !ex_mr && (ex_rd == src)) return 2'b10;
        if (mem_rw && (mem_rd == src)) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        w_ex_load_live = r_ex_memread && r_ex_regwrite && !is_r0(r_ex_rd);
        w_stall  = w_ex_load_live && !Br_Taken &&
                   ((r_ex_rd == ID_Rs) || (ID_UsesRt && (r_ex_rd == ID_Rt)));
        w_bubble = w_stall || Br_Taken;
        w_sel_a  = 2'b00;
        w_sel_b  = 2'b00;
        if (!w_bubble) begin
            w_sel_a = fwd_sel(ID_Rs, r_ex_rd, r_ex_regwrite, r_ex_memread,
                              r_mem_rd, r_mem_regwrite);
            if (ID_UsesRt)
                w_sel_b = fwd_sel(ID_Rt, r_ex_rd, r_ex_regwrite, r_ex_memread,
                                  r_mem_rd, r_mem_regwrite);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_ex_rd        <= '0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_regwrite <= 1'b0;
            r_fwd_a        <= 2'b00;
            r_fwd_b        <= 2'b00;
        end else begin
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
            if (w_bubble) begin
                r_ex_rd       <= '0;
                r_ex_regwrite <= 1'b0;
                r_ex_memread  <= 1'b0;
            end else begin
                r_ex_rd       <= ID_Rd;
                r_ex_regwrite <= ID_RegWrite;
                r_ex_memread  <= ID_MemRead;
            end
            r_fwd_a <= w_sel_a;
            r_fwd_b <= w_sel_b;
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge Clk) begin
        if (!Reset_n)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign Stall_Cnt = r_stall_cnt;
`else
    assign Stall_Cnt = '0;
`endif

    assign ForwardA = r_fwd_a;
    assign ForwardB = r_fwd_b;
    assign Stall    = w_stall;
    assign Bubble   = w_bubble;

endmodule
